mem_bus_arbiter: RTL and testbench

Shares the single memory port between the instruction cache (demand fetches plus prefetch) and the data cache. It grants one BUS_COMMAND per cycle and forwards the memory's same-cycle response tag to the winner. It records which requester owns each outstanding tag, so returned data tags are steered only to the owning cache. It sits between icache/dcache and mem.v in the processor top level.

---
 rtl/mem_bus_arbiter_if.sv | 43 ++++
 rtl/mem_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the icache/dcache pair, the memory port and the arbiter.
// The master modport is the arbiter's view; slave is the caches/memory side.
interface mem_bus_arbiter_if;
    logic [1:0]  icache2mem_command;
    logic [63:0] icache2mem_addr;
    logic [1:0]  dcache2mem_command;
    logic [63:0] dcache2mem_addr;
    logic [63:0] dcache2mem_data;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2icache_response;
    logic [3:0]  mem2dcache_response;
    logic [3:0]  mem2icache_tag;
    logic [3:0]  mem2dcache_tag;
    logic [63:0] mem2cache_data;
    logic [3:0]  icache_outstanding;
    logic [3:0]  dcache_outstanding;
    logic        tag_error;

    modport master (
        input  icache2mem_command, icache2mem_addr,
        input  dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        input  mem2proc_response, mem2proc_tag, mem2proc_data,
        output proc2mem_command, proc2mem_addr, proc2mem_data,
        output mem2icache_response, mem2dcache_response,
        output mem2icache_tag, mem2dcache_tag, mem2cache_data,
        output icache_outstanding, dcache_outstanding, tag_error
    );

    modport slave (
        output icache2mem_command, icache2mem_addr,
        output dcache2mem_command, dcache2mem_addr, dcache2mem_data,
        output mem2proc_response, mem2proc_tag, mem2proc_data,
        input  proc2mem_command, proc2mem_addr, proc2mem_data,
        input  mem2icache_response, mem2dcache_response,
        input  mem2icache_tag, mem2dcache_tag, mem2cache_data,
        input  icache_outstanding, dcache_outstanding, tag_error
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single memory port shared by icache and dcache: same-cycle grant, response
// steering, and a tag owner table that routes returning data tags to their owner.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic              clock,
    input  logic              reset,
    mem_bus_arbiter_if.master bus
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam logic [1:0] BUS_LOAD = 2'd1;

    logic [NUM_TAGS-1:0] valid_r, valid_n_s;
    logic [NUM_TAGS-1:0] owner_r, owner_n_s;
    logic [2:0]          starve_r, starve_n_s;
    logic [3:0]          icnt_r, icnt_n_s;
    logic [3:0]          dcnt_r, dcnt_n_s;
    logic                err_r, err_n_s;

    logic        i_req_s, d_req_s, grant_i_s, grant_d_s, icache_first_s;
    logic [1:0]  win_cmd_s;
    logic        comp_s, orphan_s, alloc_s;
    logic [3:0]  resp_s, tag_s;

    // Requests are masked while reset is low so nothing is granted or routed.
    assign i_req_s        = reset && (bus.icache2mem_command != BUS_NONE);
    assign d_req_s        = reset && (bus.dcache2mem_command != BUS_NONE);
    assign icache_first_s = ({29'd0, starve_r} >= 32'(STARVE_LIMIT));
    assign resp_s         = bus.mem2proc_response;
    assign tag_s          = bus.mem2proc_tag;

    // Arbitration and steering of the winner's fields and memory response
    always_comb begin
        grant_i_s               = 1'b0;
        grant_d_s               = 1'b0;
        win_cmd_s               = BUS_NONE;
        bus.proc2mem_addr       = 64'd0;
        bus.proc2mem_data       = 64'd0;
        bus.mem2icache_response = 4'd0;
        bus.mem2dcache_response = 4'd0;
        if (i_req_s && (!d_req_s || icache_first_s)) begin
            grant_i_s               = 1'b1;
            win_cmd_s               = bus.icache2mem_command;
            bus.proc2mem_addr       = bus.icache2mem_addr;
            bus.mem2icache_response = resp_s;
        end else if (d_req_s) begin
            grant_d_s               = 1'b1;
            win_cmd_s               = bus.dcache2mem_command;
            bus.proc2mem_addr       = bus.dcache2mem_addr;
            bus.proc2mem_data       = bus.dcache2mem_data;
            bus.mem2dcache_response = resp_s;
        end else begin
            grant_i_s = 1'b0;
        end
    end

    assign bus.proc2mem_command = win_cmd_s;
    assign alloc_s = (grant_i_s || grant_d_s) && (win_cmd_s == BUS_LOAD) && (resp_s != 4'd0);

    // Returning tag lookup: route to the owner or flag an orphan
    always_comb begin
        comp_s             = 1'b0;
        orphan_s           = 1'b0;
        bus.mem2icache_tag = 4'd0;
        bus.mem2dcache_tag = 4'd0;
        if (reset && (tag_s != 4'd0)) begin
            if (valid_r[tag_s]) begin
                comp_s = 1'b1;
                if (owner_r[tag_s]) begin
                    bus.mem2dcache_tag = tag_s;
                end else begin
                    bus.mem2icache_tag = tag_s;
                end
            end else begin
                orphan_s = 1'b1;
            end
        end else begin
            comp_s = 1'b0;
        end
    end

    // Next table/counter state: completion clears before allocation sets,
    // and an overwritten entry stops counting against its previous owner
    always_comb begin
        valid_n_s = valid_r;
        owner_n_s = owner_r;
        icnt_n_s  = icnt_r;
        dcnt_n_s  = dcnt_r;
        err_n_s   = err_r | orphan_s;
        if (comp_s) begin
            valid_n_s[tag_s] = 1'b0;
            if (owner_r[tag_s]) begin
                dcnt_n_s = dcnt_n_s - 4'd1;
            end else begin
                icnt_n_s = icnt_n_s - 4'd1;
            end
        end else begin
            valid_n_s = valid_r;
        end
        if (alloc_s) begin
            if (valid_n_s[resp_s]) begin
                err_n_s = 1'b1;
                if (owner_n_s[resp_s]) begin
                    dcnt_n_s = dcnt_n_s - 4'd1;
                end else begin
                    icnt_n_s = icnt_n_s - 4'd1;
                end
            end else begin
                err_n_s = err_n_s;
            end
            valid_n_s[resp_s] = 1'b1;
            owner_n_s[resp_s] = grant_d_s;
            if (grant_d_s) begin
                dcnt_n_s = dcnt_n_s + 4'd1;
            end else begin
                icnt_n_s = icnt_n_s + 4'd1;
            end
        end else begin
            owner_n_s = owner_n_s;
        end
    end

    // Icache starvation counter: refused or denied requests count up
    always_comb begin
        starve_n_s = starve_r;
        if (i_req_s) begin
            if (grant_i_s && (resp_s != 4'd0)) begin
                starve_n_s = 3'd0;
            end else if (starve_r != 3'd7) begin
                starve_n_s = starve_r + 3'd1;
            end else begin
                starve_n_s = starve_r;
            end
        end else begin
            starve_n_s = starve_r;
        end
    end

    // State registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_r  <= '0;
            owner_r  <= '0;
            starve_r <= 3'd0;
            icnt_r   <= 4'd0;
            dcnt_r   <= 4'd0;
            err_r    <= 1'b0;
        end else begin
            valid_r  <= valid_n_s;
            owner_r  <= owner_n_s;
            starve_r <= starve_n_s;
            icnt_r   <= icnt_n_s;
            dcnt_r   <= dcnt_n_s;
            err_r    <= err_n_s;
        end
    end

    assign bus.mem2cache_data     = bus.mem2proc_data;
    assign bus.icache_outstanding = icnt_r;
    assign bus.dcache_outstanding = dcnt_r;
    assign bus.tag_error          = err_r;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: a tag-ownership map model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_mem_bus_arbiter;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int LIMIT = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT), .NUM_TAGS(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        logic [63:0] data;
        logic        chk_data;
        logic [63:0] bcast;
        logic [3:0]  iresp;
        logic [3:0]  dresp;
        logic [3:0]  itag;
        logic [3:0]  dtag;
        logic [3:0]  icnt;
        logic [3:0]  dcnt;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: tag -> owner (0 icache, 1 dcache), starvation count, sticky error
    int own[int];
    int starve = 0;
    bit err    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [3:0] cnt_of(input int who);
        int n;
        n = 0;
        foreach (own[k]) if (own[k] == who) n++;
        return 4'(n);
    endfunction

    function automatic logic [3:0] pick_free();
        int q[$];
        for (int t = 1; t < 16; t++) if (!own.exists(t)) q.push_back(t);
        if (q.size() == 0) return 4'd0;
        return 4'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    function automatic logic [3:0] pick_owned();
        int q[$];
        foreach (own[k]) q.push_back(k);
        if (q.size() == 0) return 4'd0;
        return 4'(q[$urandom_range(0, q.size() - 1)]);
    endfunction

    // One bus cycle: drive inputs, push the predicted outputs, advance the model
    task automatic cyc(input bit rst, input logic [1:0] ic, input logic [1:0] dc,
                       input logic [3:0] resp, input logic [3:0] tag);
        exp_t e;
        int   win;
        logic [63:0] ia, da, dd, md;
        @(posedge clock);
        #1;
        ia = {$urandom, $urandom};
        da = {$urandom, $urandom};
        dd = {$urandom, $urandom};
        md = {$urandom, $urandom};
        reset                  = rst;
        bus.icache2mem_command = ic;
        bus.icache2mem_addr    = ia;
        bus.dcache2mem_command = dc;
        bus.dcache2mem_addr    = da;
        bus.dcache2mem_data    = dd;
        bus.mem2proc_response  = resp;
        bus.mem2proc_tag       = tag;
        bus.mem2proc_data      = md;
        if (!rst) begin
            own.delete();
            starve = 0;
            err    = 1'b0;
        end
        win = 0;
        if (rst) begin
            if (ic != BUS_NONE && dc != BUS_NONE) win = (starve >= LIMIT) ? 1 : 2;
            else if (ic != BUS_NONE) win = 1;
            else if (dc != BUS_NONE) win = 2;
        end
        e.cmd = BUS_NONE; e.addr = 64'd0; e.data = 64'd0; e.chk_data = 1'b1;
        e.iresp = 4'd0; e.dresp = 4'd0; e.itag = 4'd0; e.dtag = 4'd0;
        e.bcast = md; e.icnt = cnt_of(0); e.dcnt = cnt_of(1); e.err = err;
        if (win == 1) begin
            e.cmd = ic; e.addr = ia; e.iresp = resp; e.chk_data = 1'b0;
        end else if (win == 2) begin
            e.cmd = dc; e.addr = da; e.data = dd; e.dresp = resp;
        end
        if (rst && tag != 4'd0 && own.exists(int'(tag))) begin
            if (own[int'(tag)] == 0) e.itag = tag;
            else e.dtag = tag;
        end
        sb.push_back(e);
        if (rst) begin
            if (tag != 4'd0) begin
                if (own.exists(int'(tag))) own.delete(int'(tag));
                else err = 1'b1;
            end
            if (win != 0 && e.cmd == BUS_LOAD && resp != 4'd0) begin
                if (own.exists(int'(resp))) err = 1'b1;
                own[int'(resp)] = win - 1;
            end
            if (ic != BUS_NONE) begin
                if (win == 1 && resp != 4'd0) starve = 0;
                else if (starve < 7) starve++;
            end
        end
    endtask

    // Monitor: compare every presented cycle against the oldest prediction
    initial begin
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("cmd",   64'(bus.proc2mem_command), 64'(e.cmd));
                chk("addr",  bus.proc2mem_addr, e.addr);
                if (e.chk_data) chk("data", bus.proc2mem_data, e.data);
                chk("bcast", bus.mem2cache_data, e.bcast);
                chk("iresp", 64'(bus.mem2icache_response), 64'(e.iresp));
                chk("dresp", 64'(bus.mem2dcache_response), 64'(e.dresp));
                chk("itag",  64'(bus.mem2icache_tag), 64'(e.itag));
                chk("dtag",  64'(bus.mem2dcache_tag), 64'(e.dtag));
                chk("icnt",  64'(bus.icache_outstanding), 64'(e.icnt));
                chk("dcnt",  64'(bus.dcache_outstanding), 64'(e.dcnt));
                chk("err",   64'(bus.tag_error), 64'(e.err));
            end
        end
    end

    initial begin
        int k1, k2;
        bit rst;
        logic [1:0] ic, dc;
        logic [3:0] resp, tag;

        bus.icache2mem_command = BUS_NONE;
        bus.icache2mem_addr    = 64'd0;
        bus.dcache2mem_command = BUS_NONE;
        bus.dcache2mem_addr    = 64'd0;
        bus.dcache2mem_data    = 64'd0;
        bus.mem2proc_response  = 4'd0;
        bus.mem2proc_tag       = 4'd0;
        bus.mem2proc_data      = 64'd0;

        // Requests during reset must stay masked
        repeat (3) cyc(1'b0, BUS_LOAD, BUS_LOAD, 4'd1, 4'd3);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);

        // Icache-only load, tag returns two cycles later
        cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd3, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd3);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);

        // Both loading: dcache wins until the icache starves
        for (int k = 5; k <= 9; k++) cyc(1'b1, BUS_LOAD, BUS_LOAD, 4'(k), 4'd0);
        for (int k = 5; k <= 9; k++) cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'(k));

        // Store never allocates; its tag returning is an error
        cyc(1'b1, BUS_NONE, BUS_STORE, 4'd2, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd2);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b0, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);

        // Same-cycle complete (icache) and reallocate (dcache) of tag 4
        cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd4, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_LOAD, 4'd4, 4'd4);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd4);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);

        // Three refusals leave starvation at 3: dcache wins once, then icache
        repeat (3) cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_LOAD, BUS_LOAD, 4'd10, 4'd0);
        cyc(1'b1, BUS_LOAD, BUS_LOAD, 4'd11, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd10);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd11);

        // Reset mid-stream discards outstanding tags
        cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd1, 4'd0);
        cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd2, 4'd0);
        cyc(1'b1, BUS_LOAD, BUS_NONE, 4'd3, 4'd0);
        cyc(1'b0, BUS_LOAD, BUS_LOAD, 4'd5, 4'd1);
        cyc(1'b0, BUS_NONE, BUS_NONE, 4'd0, 4'd0);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd2);
        cyc(1'b1, BUS_NONE, BUS_NONE, 4'd0, 4'd0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 99) != 0);
            ic  = ($urandom_range(0, 1) != 0) ? BUS_LOAD : BUS_NONE;
            k1  = $urandom_range(0, 3);
            dc  = (k1 == 1) ? BUS_LOAD : ((k1 == 2) ? BUS_STORE : ((k1 == 3) ? BUS_LOAD : BUS_NONE));
            k1  = $urandom_range(0, 19);
            if (k1 < 3) resp = 4'd0;
            else if (k1 < 5) resp = 4'($urandom_range(1, 15));
            else resp = pick_free();
            k2  = $urandom_range(0, 19);
            if (k2 < 8) tag = 4'd0;
            else if (k2 < 19) tag = pick_owned();
            else tag = 4'($urandom_range(1, 15));
            cyc(rst, ic, dc, resp, tag);
        end

        repeat (2) @(negedge clock);
        chk("drain", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
